// File: rtl/std_divmod_pkg.sv
// Shared types and helpers for the streaming unsigned divide/modulo block.
package std_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Number of bits needed to index 'value' distinct items (value >= 2).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/std_divmod_core.sv
// Restoring shift-subtract divider: one quotient bit per step, MSB first.
// Zero operands are resolved at load so the caller can skip the iterations.
module std_divmod_core
  import std_divmod_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  input  logic             step,
  output logic [width-1:0] quot,
  output logic [width-1:0] rem,
  output logic             last
);

  localparam int CW = clog2(width);

  logic [width-1:0] q;
  logic [width-1:0] r;
  logic [width-1:0] d;
  logic [CW-1:0]    cnt;
  logic [width:0]   partial;
  logic [width-1:0] diff;

  // Partial remainder is width+1 bits wide. When it is >= d the difference
  // is below d, so its low width bits are the exact result.
  assign partial = {r, q[width-1]};
  assign diff    = partial[width-1:0] - d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (load) begin
      d   <= right;
      cnt <= CW'(width - 1);
      if (right == '0) begin
        q <= '1;
        r <= left;
      end else if (left == '0) begin
        q <= '0;
        r <= '0;
      end else begin
        q <= left;
        r <= '0;
      end
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (partial >= {1'b0, d}) begin
        r <= diff;
        q <= {q[width-2:0], 1'b1};
      end else begin
        r <= partial[width-1:0];
        q <= {q[width-2:0], 1'b0};
      end
    end
  end

  assign quot = q;
  assign rem  = r;
  assign last = (cnt == '0);

endmodule

// File: rtl/std_divmod_stream.sv
// Streaming div/mod: input FIFO, iterative core, registered output stage.
// Both streams transfer on a rising edge with valid && ready; valid never waits on ready.
module std_divmod_stream
  import std_divmod_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_left,
  input  logic [width-1:0] in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_quot,
  output logic [width-1:0] out_rem,
  output logic             out_div_zero
);

  localparam int PW = clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [width-1:0] fifo_left  [depth];
  logic [width-1:0] fifo_right [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [width-1:0] head_left;
  logic [width-1:0] head_right;

  state_t           state;
  logic             div_zero_pend;
  logic [width-1:0] core_quot;
  logic [width-1:0] core_rem;
  logic             core_last;

  // No pass-through: a full FIFO refuses input even while it is being popped.
  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign head_left  = fifo_left[rd_ptr];
  assign head_right = fifo_right[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_left[wr_ptr]  <= in_left;
      fifo_right[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  std_divmod_core #(.width(width)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pop),
    .left    (head_left),
    .right   (head_right),
    .step    (state == RUN),
    .quot    (core_quot),
    .rem     (core_rem),
    .last    (core_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      div_zero_pend <= 1'b0;
      out_valid     <= 1'b0;
      out_quot      <= '0;
      out_rem       <= '0;
      out_div_zero  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            div_zero_pend <= (head_right == '0);
            if (head_right == '0 || head_left == '0) state <= DONE;
            else                                     state <= RUN;
          end
        end
        RUN: begin
          if (core_last) state <= DONE;
        end
        DONE: begin
          // A write on the same edge as a consume keeps out_valid high.
          if (!out_valid || out_ready) begin
            out_valid    <= 1'b1;
            out_quot     <= core_quot;
            out_rem      <= core_rem;
            out_div_zero <= div_zero_pend;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
